// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control unit.
// Define LC3_TRAP_EN to build the TRAP microsequence (T0..T2); otherwise TRAP halts.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC,
    S_ALU, S_BRT, S_BRN, S_JMP, S_JSR0, S_JSR1, S_LEA,
    S_A0, S_R0, S_W0, S_S0, S_S1, S_I0, S_I1, S_HALT
`ifdef LC3_TRAP_EN
    , S_T0, S_T1, S_T2
`endif
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
`ifdef LC3_TRAP_EN
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
`endif
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_OFF6  = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF11 = 2'b10;
  localparam logic [1:0] ADDR2_ZERO  = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux, sr2mux;
    logic [1:0] aluk;
    logic [2:0] dr, sr1, sr2;
    logic       mio_en, mem_en, rw, halted;
  } ctrl_t;

  // States that wait for the memory handshake before advancing.
  function automatic logic is_mem_state(state_e s);
    return (s == S_F1) || (s == S_R0) || (s == S_I0) || (s == S_S1)
`ifdef LC3_TRAP_EN
        || (s == S_T1)
`endif
        ;
  endfunction

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational control-word decode from the current state and IR.
module lc3_ctrl_decode
  import lc3_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [15:0] ir_i,
  output ctrl_t       ctrl_o
);

  logic [3:0] op;
  logic       base_rel;
  logic       unused_ir;

  assign op        = ir_i[15:12];
  assign base_rel  = (op == OP_LDR) || (op == OP_STR);
  assign unused_ir = ^ir_i[4:3];

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_F0: begin
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_mar  = 1'b1;
        ctrl_o.ld_pc   = 1'b1;
        ctrl_o.pcmux   = PCMUX_INC;
      end
      S_F1, S_R0, S_I0: begin
        ctrl_o.mem_en = 1'b1;
        ctrl_o.mio_en = 1'b1;
        ctrl_o.ld_mdr = 1'b1;
      end
      S_F2: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_ir    = 1'b1;
      end
      S_ALU: begin
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.dr       = ir_i[11:9];
        ctrl_o.sr1      = ir_i[8:6];
        ctrl_o.sr2      = ir_i[2:0];
        ctrl_o.sr2mux   = ir_i[5];
        ctrl_o.aluk     = (op == OP_AND) ? ALUK_AND : (op == OP_NOT) ? ALUK_NOT : ALUK_ADD;
      end
      S_BRT: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDR;
        ctrl_o.addr2mux = ADDR2_OFF9;
      end
      S_JMP: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDR;
        ctrl_o.addr1mux = 1'b1;
        ctrl_o.addr2mux = ADDR2_ZERO;
        ctrl_o.sr1      = ir_i[8:6];
      end
      S_JSR0: begin
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_reg  = 1'b1;
        ctrl_o.dr      = 3'd7;
      end
      S_JSR1: begin
        ctrl_o.ld_pc = 1'b1;
        ctrl_o.pcmux = PCMUX_ADDR;
        if (ir_i[11]) begin
          ctrl_o.addr2mux = ADDR2_OFF11;
        end else begin
          ctrl_o.addr1mux = 1'b1;
          ctrl_o.addr2mux = ADDR2_ZERO;
          ctrl_o.sr1      = ir_i[8:6];
        end
      end
      S_LEA: begin
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.marmux      = 1'b1;
        ctrl_o.addr2mux    = ADDR2_OFF9;
        ctrl_o.ld_reg      = 1'b1;
        ctrl_o.dr          = ir_i[11:9];
      end
      S_A0: begin
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.marmux      = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
        if (base_rel) begin
          ctrl_o.addr1mux = 1'b1;
          ctrl_o.addr2mux = ADDR2_OFF6;
          ctrl_o.sr1      = ir_i[8:6];
        end else begin
          ctrl_o.addr2mux = ADDR2_OFF9;
        end
      end
      S_I1: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_mar   = 1'b1;
      end
      S_W0: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.dr       = ir_i[11:9];
      end
      // Store source lives in IR[11:9]; kept selected through the write.
      S_S0: begin
        ctrl_o.aluk     = ALUK_PASSA;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_mdr   = 1'b1;
        ctrl_o.sr1      = ir_i[11:9];
      end
      S_S1: begin
        ctrl_o.mem_en = 1'b1;
        ctrl_o.rw     = 1'b1;
        ctrl_o.sr1    = ir_i[11:9];
      end
      S_HALT: ctrl_o.halted = 1'b1;
`ifdef LC3_TRAP_EN
      S_T0: begin
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_T1: begin
        ctrl_o.mem_en  = 1'b1;
        ctrl_o.mio_en  = 1'b1;
        ctrl_o.ld_mdr  = 1'b1;
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_reg  = 1'b1;
        ctrl_o.dr      = 3'd7;
      end
      S_T2: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_BUS;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control unit: state register and next-state sequencing.
// Optional TRAP microsequence is enabled with LC3_TRAP_EN.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        MEM_R,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX_SEL,
  output logic        ADDR1MUX_SEL,
  output logic [1:0]  ADDR2MUX_SEL,
  output logic        MARMUX_SEL,
  output logic        SR2MUX_SEL,
  output logic [1:0]  ALUK,
  output logic [2:0]  DR,
  output logic [2:0]  SR1_SEL,
  output logic [2:0]  SR2_SEL,
  output logic        MIO_EN,
  output logic        MEM_EN,
  output logic        RW,
  output logic        HALTED
);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic       br_taken;

  assign opcode   = IR[15:12];
  assign br_taken = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!(is_mem_state(state_q) && !MEM_R)) begin
      case (state_q)
        S_RST: state_d = S_F0;
        S_F0:  state_d = S_F1;
        S_F1:  state_d = S_F2;
        S_F2:  state_d = S_DEC;
        // Branch resolved here so the execute state stays a pure Moore decode.
        S_DEC: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT:         state_d = S_ALU;
            OP_BR:                          state_d = br_taken ? S_BRT : S_BRN;
            OP_JMP:                         state_d = S_JMP;
            OP_JSR:                         state_d = S_JSR0;
            OP_LEA:                         state_d = S_LEA;
            OP_LD, OP_LDR, OP_ST, OP_STR,
            OP_LDI, OP_STI:                 state_d = S_A0;
            OP_RTI, OP_RES:                 state_d = S_HALT;
`ifdef LC3_TRAP_EN
            OP_TRAP:                        state_d = S_T0;
`else
            OP_TRAP:                        state_d = S_HALT;
`endif
            default:                        state_d = S_HALT;
          endcase
        end
        S_ALU, S_BRT, S_BRN, S_JMP, S_JSR1, S_LEA, S_W0, S_S1: state_d = S_F0;
        S_JSR0: state_d = S_JSR1;
        S_A0: begin
          if (opcode == OP_LDI || opcode == OP_STI)     state_d = S_I0;
          else if (opcode == OP_LD || opcode == OP_LDR) state_d = S_R0;
          else                                          state_d = S_S0;
        end
        S_I0: state_d = S_I1;
        S_I1: state_d = (opcode == OP_LDI) ? S_R0 : S_S0;
        S_R0: state_d = S_W0;
        S_S0: state_d = S_S1;
`ifdef LC3_TRAP_EN
        S_T0: state_d = S_T1;
        S_T1: state_d = S_T2;
        S_T2: state_d = S_F0;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  lc3_ctrl_decode u_decode (
    .state_i (state_q),
    .ir_i    (IR),
    .ctrl_o  (ctrl)
  );

  assign LD_MAR       = ctrl.ld_mar;
  assign LD_MDR       = ctrl.ld_mdr;
  assign LD_IR        = ctrl.ld_ir;
  assign LD_PC        = ctrl.ld_pc;
  assign LD_REG       = ctrl.ld_reg;
  assign LD_CC        = ctrl.ld_cc;
  assign GatePC       = ctrl.gate_pc;
  assign GateMDR      = ctrl.gate_mdr;
  assign GateALU      = ctrl.gate_alu;
  assign GateMARMUX   = ctrl.gate_marmux;
  assign PCMUX_SEL    = ctrl.pcmux;
  assign ADDR1MUX_SEL = ctrl.addr1mux;
  assign ADDR2MUX_SEL = ctrl.addr2mux;
  assign MARMUX_SEL   = ctrl.marmux;
  assign SR2MUX_SEL   = ctrl.sr2mux;
  assign ALUK         = ctrl.aluk;
  assign DR           = ctrl.dr;
  assign SR1_SEL      = ctrl.sr1;
  assign SR2_SEL      = ctrl.sr2;
  assign MIO_EN       = ctrl.mio_en;
  assign MEM_EN       = ctrl.mem_en;
  assign RW           = ctrl.rw;
  assign HALTED       = ctrl.halted;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench: per-instruction microstep plans queue expected control words;
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic       gpc, gmdr, galu, gmarmux;
    logic [1:0] pcmux;
    logic       addr1;
    logic [1:0] addr2;
    logic       marmux, sr2mux;
    logic [1:0] aluk;
    logic [2:0] dr, sr1, sr2;
    logic       mio, mem_en, rw, halted;
  } cw_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [15:0] IR;
  logic        N, Z, P, MEM_R;
  logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX_SEL, ADDR2MUX_SEL, ALUK;
  logic        ADDR1MUX_SEL, MARMUX_SEL, SR2MUX_SEL;
  logic [2:0]  DR, SR1_SEL, SR2_SEL;
  logic        MIO_EN, MEM_EN, RW, HALTED;

  lc3_control_fsm dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .IR(IR), .N(N), .Z(Z), .P(P), .MEM_R(MEM_R),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .GatePC(GatePC), .GateMDR(GateMDR),
    .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX_SEL(PCMUX_SEL),
    .ADDR1MUX_SEL(ADDR1MUX_SEL), .ADDR2MUX_SEL(ADDR2MUX_SEL),
    .MARMUX_SEL(MARMUX_SEL), .SR2MUX_SEL(SR2MUX_SEL), .ALUK(ALUK),
    .DR(DR), .SR1_SEL(SR1_SEL), .SR2_SEL(SR2_SEL), .MIO_EN(MIO_EN),
    .MEM_EN(MEM_EN), .RW(RW), .HALTED(HALTED)
  );

  always #5 i_Clk = ~i_Clk;

  int    errors = 0;
  int    checks = 0;
  cw_t   exp_q[$];
  string lbl_q[$];
  cw_t   plan_cw[$];
  bit    plan_mem[$];
  string plan_lbl[$];

  function automatic cw_t actual();
    cw_t a;
    a.ld_mar = LD_MAR;   a.ld_mdr = LD_MDR;  a.ld_ir = LD_IR;   a.ld_pc = LD_PC;
    a.ld_reg = LD_REG;   a.ld_cc = LD_CC;    a.gpc = GatePC;    a.gmdr = GateMDR;
    a.galu = GateALU;    a.gmarmux = GateMARMUX;
    a.pcmux = PCMUX_SEL; a.addr1 = ADDR1MUX_SEL; a.addr2 = ADDR2MUX_SEL;
    a.marmux = MARMUX_SEL; a.sr2mux = SR2MUX_SEL; a.aluk = ALUK;
    a.dr = DR; a.sr1 = SR1_SEL; a.sr2 = SR2_SEL;
    a.mio = MIO_EN; a.mem_en = MEM_EN; a.rw = RW; a.halted = HALTED;
    return a;
  endfunction

  task automatic check_cw(input string name, input cw_t e);
    cw_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: control word got %h, expected %h", name, $time, a, e);
    end
  endtask

  always @(negedge i_Clk) begin : monitor
    cw_t   e;
    string l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      check_cw(l, e);
    end
  end

  task automatic step(input cw_t c, input logic m, input string l);
    MEM_R = m;
    exp_q.push_back(c);
    lbl_q.push_back(l);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic add_step(input cw_t c, input bit m, input string l);
    plan_cw.push_back(c);
    plan_mem.push_back(m);
    plan_lbl.push_back(l);
  endtask

  task automatic mem_read(input string l);
    cw_t c = '0;
    c.mem_en = 1; c.mio = 1; c.ld_mdr = 1;
    add_step(c, 1, l);
  endtask

  task automatic calc_addr(input logic [15:0] ir);
    cw_t c = '0;
    c.gmarmux = 1; c.marmux = 1; c.ld_mar = 1;
    if (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) begin
      c.addr1 = 1; c.addr2 = 2'b00; c.sr1 = ir[8:6];
    end else begin
      c.addr2 = 2'b01;
    end
    add_step(c, 0, "A0");
  endtask

  task automatic indirect();
    cw_t c = '0;
    mem_read("I0");
    c.gmdr = 1; c.ld_mar = 1;
    add_step(c, 0, "I1");
  endtask

  task automatic load_tail(input logic [15:0] ir);
    cw_t c = '0;
    mem_read("R0");
    c.gmdr = 1; c.ld_reg = 1; c.ld_cc = 1; c.dr = ir[11:9];
    add_step(c, 0, "W0");
  endtask

  task automatic store_tail(input logic [15:0] ir);
    cw_t c = '0;
    c.aluk = 2'b11; c.galu = 1; c.ld_mdr = 1; c.sr1 = ir[11:9];
    add_step(c, 0, "S0");
    c = '0;
    c.mem_en = 1; c.rw = 1; c.sr1 = ir[11:9];
    add_step(c, 1, "S1");
  endtask

  // Reference: the sequence of bus transfers each LC-3 instruction performs.
  task automatic plan_instr(input logic [15:0] ir, input logic n, input logic z, input logic p);
    cw_t c;
    plan_cw.delete(); plan_mem.delete(); plan_lbl.delete();
    c = '0; c.gpc = 1; c.ld_mar = 1; c.ld_pc = 1;   add_step(c, 0, "F0");
    mem_read("F1");
    c = '0; c.gmdr = 1; c.ld_ir = 1;                add_step(c, 0, "F2");
    c = '0;                                         add_step(c, 0, "DEC");
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: begin
        c = '0; c.galu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.dr = ir[11:9]; c.sr1 = ir[8:6]; c.sr2 = ir[2:0]; c.sr2mux = ir[5];
        c.aluk = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
        add_step(c, 0, "ALU");
      end
      4'h0: begin
        c = '0;
        if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
          c.ld_pc = 1; c.pcmux = 2'b10; c.addr2 = 2'b01;
        end
        add_step(c, 0, "BR");
      end
      4'hC: begin
        c = '0; c.ld_pc = 1; c.pcmux = 2'b10; c.addr1 = 1; c.addr2 = 2'b11; c.sr1 = ir[8:6];
        add_step(c, 0, "JMP");
      end
      4'h4: begin
        c = '0; c.gpc = 1; c.ld_reg = 1; c.dr = 3'd7;
        add_step(c, 0, "JSR0");
        c = '0; c.ld_pc = 1; c.pcmux = 2'b10;
        if (ir[11]) c.addr2 = 2'b10;
        else begin c.addr1 = 1; c.addr2 = 2'b11; c.sr1 = ir[8:6]; end
        add_step(c, 0, "JSR1");
      end
      4'hE: begin
        c = '0; c.gmarmux = 1; c.marmux = 1; c.addr2 = 2'b01; c.ld_reg = 1; c.dr = ir[11:9];
        add_step(c, 0, "LEA");
      end
      4'h2, 4'h6: begin calc_addr(ir); load_tail(ir); end
      4'h3, 4'h7: begin calc_addr(ir); store_tail(ir); end
      4'hA:       begin calc_addr(ir); indirect(); load_tail(ir); end
      4'hB:       begin calc_addr(ir); indirect(); store_tail(ir); end
      default: ;
    endcase
  endtask

  // wait_cycles < 0 picks a random 0..3 stall per memory access.
  task automatic run_instr(input logic [15:0] ir, input logic n, input logic z,
                           input logic p, input int wait_cycles);
    int w;
    N = n; Z = z; P = p;
    plan_instr(ir, n, z, p);
    for (int i = 0; i < plan_cw.size(); i++) begin
      if (plan_lbl[i] == "DEC") IR = ir;
      if (plan_mem[i]) begin
        w = (wait_cycles >= 0) ? wait_cycles : int'($urandom_range(0, 3));
        repeat (w) step(plan_cw[i], 1'b0, plan_lbl[i]);
        step(plan_cw[i], 1'b1, plan_lbl[i]);
      end else begin
        step(plan_cw[i], 1'($urandom_range(0, 1)), plan_lbl[i]);
      end
    end
  endtask

  initial begin : stim
    logic [3:0] legal [13];
    logic [15:0] ir;
    cw_t hcw;
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    i_Rst = 1'b1; IR = '0; N = 0; Z = 0; P = 0; MEM_R = 0;
    #2;
    check_cw("reset_outputs", '0);
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    step('0, 1'b1, "RST");

    run_instr(16'h12A3, 0, 0, 0, 0);   // ADD R1,R2,#3
    run_instr(16'h0405, 0, 1, 0, 0);   // BRz taken
    run_instr(16'h0405, 1, 0, 1, 0);   // BRz not taken
    run_instr(16'hA002, 0, 0, 0, 3);   // LDI, 3 stall cycles per access
    run_instr(16'h7A41, 0, 0, 0, -1);  // STR R5,R1,#1
    run_instr(16'h4800, 0, 0, 0, 1);   // JSR off11
    run_instr(16'h4080, 0, 0, 0, 1);   // JSRR

    for (int k = 0; k < 200; k++) begin
      ir = {legal[$urandom_range(0, 12)], 12'($urandom)};
      run_instr(ir, 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    // Reserved opcode: halts until reset, then restarts at F0.
    run_instr(16'hD000, 0, 0, 0, 0);
    hcw = '0; hcw.halted = 1;
    repeat (20) step(hcw, 1'($urandom_range(0, 1)), "HALT");
    i_Rst = 1'b1;
    step('0, 1'b0, "RST_HELD");
    i_Rst = 1'b0;
    step('0, 1'b0, "RST_AFTER_HALT");
    run_instr(16'h5A7F, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stalled fetch read.
    plan_instr(16'h2001, 0, 0, 0);
    step(plan_cw[0], 1'b0, "F0");
    MEM_R = 1'b0;
    exp_q.push_back(plan_cw[1]);
    lbl_q.push_back("F1_before_reset");
    @(negedge i_Clk);
    #1;
    i_Rst = 1'b1;
    #1;
    check_cw("async_reset_mid_F1", '0);
    @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    step('0, 1'b0, "RST_AFTER_ASYNC");
    run_instr(16'h2001, 0, 0, 0, 2);

    repeat (2) @(posedge i_Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
